// File: rtl/pipeline_hazard_int_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_int_ctrl
//
// Purpose
//   Combined pipeline hazard controller and interrupt sequencer. In normal
//   operation it resolves branch flushes and load-use stalls combinationally.
//   On a rising edge of interrupt_signal it drains the pipeline for
//   DRAIN_CYCLES bubbles. It then pushes the PC (LSW first) and a flags word
//   as DATA_W-wide stack words, and finally loads the interrupt vector into
//   the PC.
//
// Optional feature (compile-time macro INT_PENDING_EN)
//   Defined   : an interrupt edge seen while the sequencer is busy is
//               remembered in a single pending bit. VECTOR then re-enters
//               DRAIN instead of returning to IDLE.
//   Undefined : edges outside IDLE are dropped. No pending register exists.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   interrupt_signal  external interrupt request (edge detected)
//   branch_result     branch taken, resolved in execute
//   mem_read_dec      decode-stage instruction is a load
//   r_dst_dec         decode-stage destination register
//   r_src_fetch       fetch-stage source register
//   r_dst_fetch       fetch-stage destination register
//   int_push_ready    stack port accepts a push this cycle
//   pc_write          PC register update enable
//   stall_fetch       hold fetch pipeline register
//   stall_decode      hold decode pipeline register
//   flush_fetch       clear fetch-stage instruction
//   flush_decode      insert bubble into decode output
//   int_push_valid    push word requested
//   int_push_idx      word select: 0 = PC LSW .. PUSH_WORDS-1 = flags
//   int_pc_load       PC mux selects int_vector
//   int_vector        interrupt vector address (VECTOR_ADDR)
//   int_busy          sequencer not idle
// ---------------------------------------------------------------------------
module pipeline_hazard_int_ctrl #(
    parameter int              DATA_W       = 16,
    parameter int              PC_W         = 32,
    parameter int              REG_AW       = 3,
    parameter int              DRAIN_CYCLES = 3,
    parameter logic [PC_W-1:0] VECTOR_ADDR  = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                interrupt_signal,
    input  logic                                branch_result,
    input  logic                                mem_read_dec,
    input  logic [REG_AW-1:0]                   r_dst_dec,
    input  logic [REG_AW-1:0]                   r_src_fetch,
    input  logic [REG_AW-1:0]                   r_dst_fetch,
    input  logic                                int_push_ready,
    output logic                                pc_write,
    output logic                                stall_fetch,
    output logic                                stall_decode,
    output logic                                flush_fetch,
    output logic                                flush_decode,
    output logic                                int_push_valid,
    output logic [$clog2(PC_W/DATA_W+1)-1:0]    int_push_idx,
    output logic                                int_pc_load,
    output logic [PC_W-1:0]                     int_vector,
    output logic                                int_busy
);

    localparam int PUSH_WORDS = PC_W / DATA_W + 1;
    localparam int IDX_W      = $clog2(PUSH_WORDS);

    localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [IDX_W-1:0] WORD_LAST  = IDX_W'(PUSH_WORDS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_PUSH   = 2'd2;
    localparam logic [1:0] S_VECTOR = 2'd3;

    logic [1:0]       r_state;
    logic [3:0]       r_drain_cnt;
    logic [IDX_W-1:0] r_word_cnt;
    logic             r_irq_q;

    logic w_irq_edge;
    logic w_load_use;
    logic w_restart;

    assign w_irq_edge = interrupt_signal & ~r_irq_q;
    assign w_load_use = mem_read_dec &
                        ((r_dst_dec == r_src_fetch) | (r_dst_dec == r_dst_fetch));

`ifdef INT_PENDING_EN
    logic r_pending;

    // An edge arriving in VECTOR itself counts as well, so that it is not lost
    // when the pending bit is being cleared in the same cycle.
    assign w_restart = r_pending | w_irq_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (r_state == S_VECTOR) begin
            r_pending <= 1'b0;
        end else if (w_irq_edge && (r_state != S_IDLE)) begin
            r_pending <= 1'b1;
        end
    end
`else
    assign w_restart = 1'b0;
`endif

    // Edge register resets to 1 so that a level already high when reset is
    // released does not look like a new request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
            r_word_cnt  <= '0;
            r_irq_q     <= 1'b1;
        end else begin
            r_irq_q <= interrupt_signal;
            case (r_state)
                S_IDLE: begin
                    if (w_irq_edge) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= '0;
                        r_word_cnt  <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state     <= S_PUSH;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 4'd1;
                    end
                end
                S_PUSH: begin
                    // int_push_valid is always high here, so a push
                    // handshake reduces to int_push_ready.
                    if (int_push_ready) begin
                        if (r_word_cnt == WORD_LAST) begin
                            r_state    <= S_VECTOR;
                            r_word_cnt <= '0;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                end
                S_VECTOR: begin
                    r_state <= w_restart ? S_DRAIN : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pc_write       = 1'b0;
        stall_fetch    = 1'b0;
        stall_decode   = 1'b0;
        flush_fetch    = 1'b0;
        flush_decode   = 1'b0;
        int_push_valid = 1'b0;
        int_push_idx   = '0;
        int_pc_load    = 1'b0;
        int_vector     = '0;
        int_busy       = 1'b0;
        if (rst) begin
            flush_fetch  = 1'b1;
            flush_decode = 1'b1;
        end else begin
            int_vector = VECTOR_ADDR;
            case (r_state)
                S_IDLE: begin
                    if (branch_result) begin
                        flush_fetch  = 1'b1;
                        flush_decode = 1'b1;
                        pc_write     = 1'b1;
                    end else if (w_load_use) begin
                        stall_fetch  = 1'b1;
                        flush_decode = 1'b1;
                    end else begin
                        pc_write = 1'b1;
                    end
                end
                S_DRAIN: begin
                    int_busy     = 1'b1;
                    stall_fetch  = 1'b1;
                    flush_decode = 1'b1;
                    flush_fetch  = branch_result;
                end
                S_PUSH: begin
                    int_busy       = 1'b1;
                    stall_fetch    = 1'b1;
                    flush_decode   = 1'b1;
                    int_push_valid = 1'b1;
                    int_push_idx   = r_word_cnt;
                end
                S_VECTOR: begin
                    int_busy     = 1'b1;
                    int_pc_load  = 1'b1;
                    pc_write     = 1'b1;
                    flush_fetch  = 1'b1;
                    flush_decode = 1'b1;
                end
                default: begin
                    int_busy = 1'b0;
                end
            endcase
        end
    end

endmodule
